ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, sets the width of every address bus.
REQ-002 Parameter DATA_WIDTH, default 16, sets the width of every data bus.
REQ-003 clock  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_req_valid  input  1  fetch read request present.
REQ-006 fetch_req_ready  output  1  fetch request accepted this cycle.
REQ-007 fetch_address  input  ADDRESS_WIDTH  fetch read address.
REQ-008 fetch_resp_valid  output  1  fetch read data valid this cycle.
REQ-009 fetch_resp_data  output  DATA_WIDTH  fetch read data.
REQ-010 data_req_valid  input  1  load/store request present.
REQ-011 data_req_ready  output  1  load/store request accepted this cycle.
REQ-012 data_req_rw  input  1  0 = read, 1 = write.
REQ-013 data_address  input  ADDRESS_WIDTH  load/store address.
REQ-014 data_write_data  input  DATA_WIDTH  store data.
REQ-015 data_resp_valid  output  1  load data valid, or store acknowledged.
REQ-016 data_resp_data  output  DATA_WIDTH  load data; meaningful only for reads.
REQ-017 ram_enable, ram_rw  output  1 each  to the synchronous single-port RAM (rw: 0 = read, 1 = write).
REQ-018 ram_address  output  ADDRESS_WIDTH;  ram_data_in  output  DATA_WIDTH;  ram_data_out  input  DATA_WIDTH (RAM registered read data).

Function
REQ-019 A request is accepted in cycle N when req_valid and req_ready are both high at the rising edge ending N.
REQ-020 At most one request SHALL be accepted per cycle; one ready at most is high in any cycle.
REQ-021 Only one port valid -> that port's ready is high in the same cycle; combinational ready from valid is permitted.
REQ-022 Both ports valid -> round-robin: grant the port not granted at the most recent acceptance; after reset the data port wins first.
REQ-023 The last_grant register SHALL update only on an acceptance; idle cycles SHALL NOT change it.
REQ-024 In the accept cycle, ram_enable = 1 and ram_rw/ram_address/ram_data_in = the winner's rw (fetch forces 0), address and write data.
REQ-025 With no acceptance, ram_enable = 0 and the other RAM outputs are don't-care.
REQ-026 For a request accepted in cycle N, the matching resp_valid SHALL be high for exactly cycle N+1, driven from a registered pending flag.
REQ-027 Read resp_data SHALL equal ram_data_out in cycle N+1; both resp_data outputs route ram_data_out without extra registering.
REQ-028 Back-to-back acceptances every cycle are supported; throughput is one request per cycle, with no bubble between ports.
REQ-029 There is no response backpressure; requesters SHALL consume the response in cycle N+1.
REQ-030 A requester SHALL hold valid, address, rw and write data stable until accepted; the arbiter does not buffer requests.

Reset
REQ-031 Reset high at a rising edge SHALL clear both pending flags and set last_grant to fetch, so data wins next.
REQ-032 During and after reset, fetch_resp_valid, data_resp_valid, fetch_req_ready, data_req_ready and ram_enable SHALL be 0 while reset is high.
REQ-033 A request accepted in the cycle before reset asserts SHALL produce no response; its RAM write may complete.

Structure
REQ-034 Shared package tau_memory_pkg SHALL hold the default ADDRESS_WIDTH/DATA_WIDTH, the constants RW_READ = 0 and RW_WRITE = 1, and the grant enum {GRANT_FETCH, GRANT_DATA}.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter_2 (two requests, last_grant register, one-hot grant out).

Verification
REQ-036 RAM preloaded mem[0x0010]=0xBEEF; fetch reads 0x0010 alone -> ready in cycle N, fetch_resp_valid with 0xBEEF in N+1 only.
REQ-037 Data write 0x0020<=0x1234, then data read 0x0020 next cycle -> write ack in N+1, read returns 0x1234 in N+2.
REQ-038 Both ports valid for 4 cycles -> grants D,F,D,F; four responses on consecutive cycles, each on the correct port.
REQ-039 Fetch alone for 3 cycles, then both valid -> data granted first in the contended cycle.
REQ-040 Reset asserted the cycle after an accepted read -> no resp_valid; after release, data wins the first contention.
REQ-041 No valid for 10 cycles -> ram_enable stays 0, last_grant unchanged, no responses.

Source files
------------

// File: rtl/tau_memory_pkg.sv
// Shared memory-subsystem definitions: default bus widths, RAM access codes
// and the grant encoding used by the port arbiters.
package tau_memory_pkg;

    localparam int unsigned ADDRESS_WIDTH_DEFAULT = 16;
    localparam int unsigned DATA_WIDTH_DEFAULT    = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. Bit 0 is the fetch port, bit 1 the data port.
// A grant is always taken (ready == grant), so every grant updates last_grant.
module rr_arbiter_2
    import tau_memory_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] request,
    output logic [1:0] grant
);

    grant_t last_grant;

    // Lone requester wins outright; under contention the other port goes next.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (request)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == GRANT_FETCH) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_FETCH;
        end else if (grant[1]) begin
            last_grant <= GRANT_DATA;
        end else if (grant[0]) begin
            last_grant <= GRANT_FETCH;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between an instruction-fetch port and
// a load/store port; one access per cycle, response exactly one cycle later.
module ram_port_arbiter
    import tau_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     fetch_req_valid,
    output logic                     fetch_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    output logic                     fetch_resp_valid,
    output logic [DATA_WIDTH-1:0]    fetch_resp_data,

    input  logic                     data_req_valid,
    output logic                     data_req_ready,
    input  logic                     data_req_rw,
    input  logic [ADDRESS_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0]    data_write_data,
    output logic                     data_resp_valid,
    output logic [DATA_WIDTH-1:0]    data_resp_data,

    output logic                     ram_enable,
    output logic                     ram_rw,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out
);

    logic [1:0] grant;
    logic       fetch_pending;
    logic       data_pending;

    rr_arbiter_2 u_rr_arbiter (
        .clock   (clock),
        .reset   (reset),
        .request ({data_req_valid, fetch_req_valid}),
        .grant   (grant)
    );

    assign fetch_req_ready = grant[0];
    assign data_req_ready  = grant[1];

    // Steer the winner onto the RAM; fetch is always a read.
    always_comb begin
        ram_enable  = |grant;
        ram_rw      = RW_READ;
        ram_address = fetch_address;
        ram_data_in = '0;
        if (grant[1]) begin
            ram_rw      = data_req_rw;
            ram_address = data_address;
            ram_data_in = data_write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pending <= 1'b0;
            data_pending  <= 1'b0;
        end else begin
            fetch_pending <= grant[0];
            data_pending  <= grant[1];
        end
    end

    // Masking with reset drops the response of an access accepted just before reset.
    assign fetch_resp_valid = fetch_pending & ~reset;
    assign data_resp_valid  = data_pending & ~reset;
    assign fetch_resp_data  = ram_data_out;
    assign data_resp_data   = ram_data_out;

endmodule
